dilithium_load_sequencer: RTL and testbench
===========================================

// Module: dilithium_load_sequencer
// PURPOSE
// - Sequences operand loading into the Dilithium core for one operation (keygen/sign/verify).
// - Host streams 64-bit words; block forwards them to the core in the fixed per-mode field order,
//   tagging each word with field id and per-field last.
// - Issues core start, then waits for core done. Sits between host/AXI-stream shim and core input port.
// PARAMETERS
// - SEC_LEVEL  2      Dilithium level (2, 3, 5); selects fixed field word counts.
// - W          64     Stream word width (bits).
// - MSG_SIZE   26400  Max message bits; MSG_LEN_SIZE = $clog2(MSG_SIZE) = 15.
// PORTS
// - clk          in   1             Clock; all logic on rising edge.
// - rst          in   1             Synchronous reset, active-high.
// - start        in   1             Operation request; sampled in IDLE only.
// - mode         in   2             00 keygen, 10 sign, 01 verify; 11 invalid.
// - msg_len      in   MSG_LEN_SIZE  Message length in bits; sampled with start.
// - busy         out  1             High from accepted start until done.
// - done         out  1             1-cycle pulse when core_done is seen in WAIT_DONE.
// - err          out  1             1-cycle pulse on start with mode 11.
// - src_valid    in   1             Host word valid.
// - src_ready    out  1             Host word accepted when src_valid & src_ready.
// - src_data     in   W             Host word.
// - core_start   out  1             1-cycle pulse to core.
// - core_mode    out  2             Latched mode; stable while busy.
// - core_valid   out  1             Word valid to core.
// - core_ready   in   1             Core accepts word.
// - core_data    out  W             Word to core (= src_data).
// - core_field   out  4             Field id of current word (package enum).
// - core_last    out  1             Current word is last of its field.
// - core_done    in   1             Core operation finished.
// BEHAVIOUR
// - Reset: state IDLE. busy, done, err, core_start, core_valid, src_ready, core_last = 0;
//   core_mode = 00; core_field = 0; counters = 0. Reset mid-stream aborts with no done pulse.
// - FSM: IDLE -> ISSUE -> STREAM -> WAIT_DONE -> IDLE.
//   - IDLE: start & valid mode -> latch mode/msg_len, go ISSUE. start & mode 11 -> err pulse, stay IDLE.
//   - ISSUE: one cycle, core_start = 1; then STREAM at field 0.
//   - STREAM: core_valid = src_valid, src_ready = core_ready, core_data = src_data
//     (combinational, 0 latency). Transfer = src_valid & core_ready.
//     word_cnt increments per transfer. At count-1, core_last = 1; on that transfer advance field,
//     word_cnt = 0. Transfer of last word of last field -> WAIT_DONE.
//   - WAIT_DONE: src_ready = 0; core_done -> done pulse, busy = 0 next cycle, IDLE.
// - start outside IDLE is ignored (no queueing).
// - Field order:
//   - keygen: SEED(4)
//   - sign:   RHO(4) K(4) TR(4) S1 S2 T0 MSG
//   - verify: RHO(4) C(4) Z T1 H MSG
// - Word counts (ceil(bits/64)):
//   - SEC2: S1 48, S2 48, T0 208, T1 160, Z 288, H 11
//   - SEC3: S1 80, S2 96, T0 312, T1 240, Z 400, H 8
//   - SEC5: S1 84, S2 96, T0 416, T1 320, Z 560, H 11
// - MSG words = (msg_len + 63) >> 6, max 413.
//   - msg_len = 0: MSG field skipped; last word of the previous field ends STREAM.
//   - Partial final word is forwarded unmodified.
// - word_cnt is 10 bits wide (max count 560). It never wraps: it clears at each field boundary.
// - core_done outside WAIT_DONE is ignored.
// STRUCTURE
// - dilithium_pkg holds:
//   - mode constants KEYGEN/SIGN/VERIFY
//   - field_t enum {SEED, RHO, K, TR, S1, S2, T0, T1, Z, H, C, MSG}
//   - per-level word-count constants
//   - function field_words(sec, field, msg_len)
// - One sub-module: dilithium_field_table (combinational).
//   Maps (mode, field index) to field_t, word count and is_final.
// - Everything else is the FSM plus counters.
// TESTING
// - Keygen, SEC2, 4 words, core_ready = 1: core_start at cycle 1; core_field = SEED;
//   core_last on word 4; WAIT_DONE; core_done -> done pulse.
// - Sign, SEC2, msg_len = 264: 321 transfers (4+4+4+48+48+208+5).
//   core_last exactly at transfers 4, 8, 12, 60, 108, 316, 321.
// - Verify, SEC5, msg_len = 0: 4+4+560+320+11 = 899 transfers; MSG never shown on core_field.
// - core_ready toggled randomly: no word dropped or duplicated; src_ready low whenever core_ready low.
// - Invalid and illegal starts:
//   - start with mode 11 -> err pulse 1 cycle; busy stays 0.
//   - start during STREAM -> ignored; sequence unaffected.
// - rst asserted at sign word 50: next cycle all outputs at reset values.
//   A fresh keygen start then completes normally.

Source files
------------

// File: rtl/dilithium_pkg.sv
// Shared definitions for the Dilithium operand load path.
// - Mode encodings used on the mode/core_mode ports.
// - field_t: the field id carried on core_field.
// - Per-level word counts (ceil(bits/64)) for the variable-size fields.
// - field_words(): word count of one field for a level and message length.
package dilithium_pkg;

    localparam logic [1:0] MODE_KEYGEN  = 2'b00;
    localparam logic [1:0] MODE_SIGN    = 2'b10;
    localparam logic [1:0] MODE_VERIFY  = 2'b01;
    localparam logic [1:0] MODE_INVALID = 2'b11;

    typedef enum logic [3:0] {
        SEED = 4'd0,
        RHO  = 4'd1,
        K    = 4'd2,
        TR   = 4'd3,
        S1   = 4'd4,
        S2   = 4'd5,
        T0   = 4'd6,
        T1   = 4'd7,
        Z    = 4'd8,
        H    = 4'd9,
        C    = 4'd10,
        MSG  = 4'd11
    } field_t;

    // 256-bit fixed fields (seed, rho, K, tr, c)
    localparam logic [9:0] FIXED_WORDS = 10'd4;

    localparam logic [9:0] SEC2_S1_WORDS = 10'd48;
    localparam logic [9:0] SEC2_S2_WORDS = 10'd48;
    localparam logic [9:0] SEC2_T0_WORDS = 10'd208;
    localparam logic [9:0] SEC2_T1_WORDS = 10'd160;
    localparam logic [9:0] SEC2_Z_WORDS  = 10'd288;
    localparam logic [9:0] SEC2_H_WORDS  = 10'd11;

    localparam logic [9:0] SEC3_S1_WORDS = 10'd80;
    localparam logic [9:0] SEC3_S2_WORDS = 10'd96;
    localparam logic [9:0] SEC3_T0_WORDS = 10'd312;
    localparam logic [9:0] SEC3_T1_WORDS = 10'd240;
    localparam logic [9:0] SEC3_Z_WORDS  = 10'd400;
    localparam logic [9:0] SEC3_H_WORDS  = 10'd8;

    localparam logic [9:0] SEC5_S1_WORDS = 10'd84;
    localparam logic [9:0] SEC5_S2_WORDS = 10'd96;
    localparam logic [9:0] SEC5_T0_WORDS = 10'd416;
    localparam logic [9:0] SEC5_T1_WORDS = 10'd320;
    localparam logic [9:0] SEC5_Z_WORDS  = 10'd560;
    localparam logic [9:0] SEC5_H_WORDS  = 10'd11;

    // Words in one field. MSG depends on the message length and may be 0.
    function automatic logic [9:0] field_words(input int sec, input field_t field,
                                               input logic [15:0] msg_len);
        logic [9:0] words;
        words = FIXED_WORDS;
        case (field)
            S1:  words = (sec == 3) ? SEC3_S1_WORDS : (sec == 5) ? SEC5_S1_WORDS : SEC2_S1_WORDS;
            S2:  words = (sec == 3) ? SEC3_S2_WORDS : (sec == 5) ? SEC5_S2_WORDS : SEC2_S2_WORDS;
            T0:  words = (sec == 3) ? SEC3_T0_WORDS : (sec == 5) ? SEC5_T0_WORDS : SEC2_T0_WORDS;
            T1:  words = (sec == 3) ? SEC3_T1_WORDS : (sec == 5) ? SEC5_T1_WORDS : SEC2_T1_WORDS;
            Z:   words = (sec == 3) ? SEC3_Z_WORDS  : (sec == 5) ? SEC5_Z_WORDS  : SEC2_Z_WORDS;
            H:   words = (sec == 3) ? SEC3_H_WORDS  : (sec == 5) ? SEC5_H_WORDS  : SEC2_H_WORDS;
            MSG: words = 10'((msg_len + 16'd63) >> 6);
            default: words = FIXED_WORDS;
        endcase
        return words;
    endfunction

endpackage

// File: rtl/dilithium_field_table.sv
// Combinational per-mode field order table.
// Ports:
//   i_mode      latched operation mode
//   i_field_idx position within the mode's field order
//   i_msg_len   message length in bits (decides whether MSG exists)
//   o_field     field id at that position
//   o_words     word count of that field
//   o_is_final  position is the last field of the operation
module dilithium_field_table
    import dilithium_pkg::*;
#(
    parameter int SEC_LEVEL = 2
)(
    input  logic [1:0]  i_mode,
    input  logic [2:0]  i_field_idx,
    input  logic [15:0] i_msg_len,
    output field_t      o_field,
    output logic [9:0]  o_words,
    output logic        o_is_final
);

    logic       w_no_msg;
    logic [2:0] w_last_idx;

    assign w_no_msg = (i_msg_len == 16'd0);

    always_comb begin
        o_field    = SEED;
        w_last_idx = 3'd0;
        case (i_mode)
            MODE_SIGN: begin
                // An empty message drops MSG, so T0 becomes the final field
                w_last_idx = w_no_msg ? 3'd5 : 3'd6;
                case (i_field_idx)
                    3'd0:    o_field = RHO;
                    3'd1:    o_field = K;
                    3'd2:    o_field = TR;
                    3'd3:    o_field = S1;
                    3'd4:    o_field = S2;
                    3'd5:    o_field = T0;
                    default: o_field = MSG;
                endcase
            end
            MODE_VERIFY: begin
                w_last_idx = w_no_msg ? 3'd4 : 3'd5;
                case (i_field_idx)
                    3'd0:    o_field = RHO;
                    3'd1:    o_field = C;
                    3'd2:    o_field = Z;
                    3'd3:    o_field = T1;
                    3'd4:    o_field = H;
                    default: o_field = MSG;
                endcase
            end
            default: begin
                o_field    = SEED;
                w_last_idx = 3'd0;
            end
        endcase
    end

    assign o_words    = field_words(SEC_LEVEL, o_field, i_msg_len);
    assign o_is_final = (i_field_idx == w_last_idx);

endmodule

// File: rtl/dilithium_load_sequencer.sv
// Operand load sequencer for one Dilithium operation (keygen/sign/verify).
// Forwards host words to the core in the fixed per-mode field order, tagging
// each word with its field id and a per-field last flag, then waits for the
// core to finish.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   start, mode, msg_len           operation request (sampled in IDLE)
//   busy, done, err                status (done/err are 1-cycle pulses)
//   src_valid, src_ready, src_data host word stream
//   core_start, core_mode          core kick-off pulse and latched mode
//   core_valid, core_ready,
//   core_data, core_field,
//   core_last                      word stream to the core
//   core_done                      core completion
module dilithium_load_sequencer
    import dilithium_pkg::*;
#(
    parameter int SEC_LEVEL = 2,
    parameter int W         = 64,
    parameter int MSG_SIZE  = 26400,
    localparam int MSG_LEN_SIZE = $clog2(MSG_SIZE)
)(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [1:0]              mode,
    input  logic [MSG_LEN_SIZE-1:0] msg_len,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    input  logic                    src_valid,
    output logic                    src_ready,
    input  logic [W-1:0]            src_data,
    output logic                    core_start,
    output logic [1:0]              core_mode,
    output logic                    core_valid,
    input  logic                    core_ready,
    output logic [W-1:0]            core_data,
    output logic [3:0]              core_field,
    output logic                    core_last,
    input  logic                    core_done
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_STREAM    = 2'd2,
        ST_WAIT_DONE = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [1:0]              r_mode;
    logic [MSG_LEN_SIZE-1:0] r_msg_len;
    logic [2:0]              r_field_idx;
    logic [9:0]              r_word_cnt;

    field_t     w_field;
    logic [9:0] w_words;
    logic       w_is_final;
    logic       w_last_word;
    logic       w_xfer;
    logic       w_accept;

    dilithium_field_table #(
        .SEC_LEVEL (SEC_LEVEL)
    ) u_field_table (
        .i_mode      (r_mode),
        .i_field_idx (r_field_idx),
        .i_msg_len   (16'(r_msg_len)),
        .o_field     (w_field),
        .o_words     (w_words),
        .o_is_final  (w_is_final)
    );

    assign w_last_word = (r_word_cnt == (w_words - 10'd1));
    assign w_accept    = (r_state == ST_IDLE) && start && (mode != MODE_INVALID);
    assign core_data   = src_data;
    assign core_mode   = r_mode;

    always_comb begin
        w_state_next = r_state;
        busy         = (r_state != ST_IDLE);
        done         = 1'b0;
        err          = 1'b0;
        core_start   = 1'b0;
        core_valid   = 1'b0;
        src_ready    = 1'b0;
        core_last    = 1'b0;
        core_field   = SEED;
        w_xfer       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (mode == MODE_INVALID) begin
                        err = 1'b1;
                    end else begin
                        w_state_next = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                core_start   = 1'b1;
                w_state_next = ST_STREAM;
            end
            ST_STREAM: begin
                // Pass-through handshake: the core's backpressure goes straight to the host
                core_valid = src_valid;
                src_ready  = core_ready;
                core_field = w_field;
                core_last  = w_last_word;
                w_xfer     = src_valid & core_ready;
                if (w_xfer && w_last_word && w_is_final) begin
                    w_state_next = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (core_done) begin
                    done         = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_mode      <= MODE_KEYGEN;
            r_msg_len   <= '0;
            r_field_idx <= 3'd0;
            r_word_cnt  <= 10'd0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_mode      <= mode;
                r_msg_len   <= msg_len;
                r_field_idx <= 3'd0;
                r_word_cnt  <= 10'd0;
            end else if (w_xfer) begin
                // Counter clears at every field boundary, so it never wraps
                if (w_last_word) begin
                    r_word_cnt  <= 10'd0;
                    r_field_idx <= r_field_idx + 3'd1;
                end else begin
                    r_word_cnt <= r_word_cnt + 10'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_dilithium_load_sequencer.sv
`timescale 1ns/1ps
module tb_dilithium_load_sequencer;
    import dilithium_pkg::*;

    localparam int W   = 64;
    localparam int MLW = 15;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst, start, src_valid, core_ready, core_done;
    logic [1:0]     mode, sel;
    logic [MLW-1:0] msg_len;
    logic [W-1:0]   src_data;

    logic         busy_a[3], done_a[3], err_a[3], src_ready_a[3];
    logic         core_start_a[3], core_valid_a[3], core_last_a[3];
    logic [1:0]   core_mode_a[3];
    logic [W-1:0] core_data_a[3];
    logic [3:0]   core_field_a[3];

    // One instance per security level; only the selected one sees start
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_dut
            localparam int LVL = (gi == 0) ? 2 : (gi == 1) ? 3 : 5;
            dilithium_load_sequencer #(
                .SEC_LEVEL (LVL),
                .W         (W),
                .MSG_SIZE  (26400)
            ) u_dut (
                .clk        (clk),
                .rst        (rst),
                .start      (start && (sel == 2'(gi))),
                .mode       (mode),
                .msg_len    (msg_len),
                .busy       (busy_a[gi]),
                .done       (done_a[gi]),
                .err        (err_a[gi]),
                .src_valid  (src_valid),
                .src_ready  (src_ready_a[gi]),
                .src_data   (src_data),
                .core_start (core_start_a[gi]),
                .core_mode  (core_mode_a[gi]),
                .core_valid (core_valid_a[gi]),
                .core_ready (core_ready),
                .core_data  (core_data_a[gi]),
                .core_field (core_field_a[gi]),
                .core_last  (core_last_a[gi]),
                .core_done  (core_done)
            );
        end
    endgenerate

    logic         busy, done, err, src_ready, core_start, core_valid, core_last;
    logic [1:0]   core_mode;
    logic [W-1:0] core_data;
    logic [3:0]   core_field;

    always_comb begin
        busy       = busy_a[sel];
        done       = done_a[sel];
        err        = err_a[sel];
        src_ready  = src_ready_a[sel];
        core_start = core_start_a[sel];
        core_valid = core_valid_a[sel];
        core_last  = core_last_a[sel];
        core_mode  = core_mode_a[sel];
        core_data  = core_data_a[sel];
        core_field = core_field_a[sel];
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference word counts per level index (0:SEC2, 1:SEC3, 2:SEC5)
    int s1_w[3] = '{48, 80, 84};
    int s2_w[3] = '{48, 96, 96};
    int t0_w[3] = '{208, 312, 416};
    int t1_w[3] = '{160, 240, 320};
    int z_w[3]  = '{288, 400, 560};
    int h_w[3]  = '{11, 8, 11};

    function automatic int words_of(input int s, input field_t f, input int ml);
        case (f)
            S1:      return s1_w[s];
            S2:      return s2_w[s];
            T0:      return t0_w[s];
            T1:      return t1_w[s];
            Z:       return z_w[s];
            H:       return h_w[s];
            MSG:     return (ml + 63) / 64;
            default: return 4;
        endcase
    endfunction

    // One operation: model queue of (field,last) per word, checked per transfer.
    // exp_total < 0 means use the model's own word total.
    task automatic run_op(input int s, input logic [1:0] md, input int ml,
                          input int rdy_pct, input int vld_pct,
                          input int inject_at, input int abort_at, input int exp_total);
        field_t order[$];
        field_t qf[$];
        bit     ql[$];
        int     xfers, cyc, n, total;
        case (md)
            MODE_KEYGEN: order = '{SEED};
            MODE_SIGN:   order = '{RHO, K, TR, S1, S2, T0, MSG};
            default:     order = '{RHO, C, Z, T1, H, MSG};
        endcase
        foreach (order[j]) begin
            n = words_of(s, order[j], ml);
            for (int w = 0; w < n; w++) begin
                qf.push_back(order[j]);
                ql.push_back(w == n - 1);
            end
        end
        total = (exp_total >= 0) ? exp_total : qf.size();
        xfers = 0;
        cyc   = 0;

        @(negedge clk);
        sel = 2'(s); start = 1'b1; mode = md; msg_len = MLW'(ml);
        src_valid = 1'b0; core_ready = 1'b0; core_done = 1'b0;
        #1;
        chk("idle_busy", busy, 1'b0);
        chk("idle_core_start", core_start, 1'b0);
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("issue_core_start", core_start, 1'b1);
        chk("issue_busy", busy, 1'b1);
        chk("issue_core_mode", core_mode, md);

        while (qf.size() > 0 && cyc < 20000) begin
            @(negedge clk);
            src_valid  = ($urandom_range(99) < vld_pct);
            core_ready = ($urandom_range(99) < rdy_pct);
            src_data   = {$urandom, $urandom};
            core_done  = ($urandom_range(7) == 0);
            start      = (inject_at >= 0 && xfers == inject_at);
            mode       = 2'($urandom_range(3));
            #1;
            chk("stream_src_ready", src_ready, core_ready);
            chk("stream_core_valid", core_valid, src_valid);
            chk("stream_core_data", core_data, src_data);
            chk("stream_done", done, 1'b0);
            chk("stream_err", err, 1'b0);
            chk("stream_busy", busy, 1'b1);
            chk("stream_core_start", core_start, 1'b0);
            chk("stream_core_mode", core_mode, md);
            if (src_valid && core_ready) begin
                chk("core_field", core_field, qf[0]);
                chk("core_last", core_last, ql[0]);
                void'(qf.pop_front());
                void'(ql.pop_front());
                xfers++;
            end
            cyc++;
            if (abort_at >= 0 && xfers == abort_at) break;
        end
        start = 1'b0;
        core_done = 1'b0;

        if (abort_at >= 0) begin
            @(negedge clk);
            rst = 1'b1; src_valid = 1'b0; core_ready = 1'b0;
            @(negedge clk);
            rst = 1'b0; src_valid = 1'b1; core_ready = 1'b1;
            #1;
            chk("rst_busy", busy, 1'b0);
            chk("rst_done", done, 1'b0);
            chk("rst_err", err, 1'b0);
            chk("rst_core_start", core_start, 1'b0);
            chk("rst_core_valid", core_valid, 1'b0);
            chk("rst_src_ready", src_ready, 1'b0);
            chk("rst_core_last", core_last, 1'b0);
            chk("rst_core_mode", core_mode, 2'b00);
            chk("rst_core_field", core_field, 4'd0);
            $display("op sel=%0d mode=%b msg_len=%0d aborted by reset after %0d transfers",
                     s, md, ml, xfers);
            src_valid = 1'b0; core_ready = 1'b0;
            return;
        end

        chk("stream_budget", 64'(qf.size()), 64'd0);
        n = $urandom_range(1, 3);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            src_valid = 1'b1; core_ready = 1'b1;
            #1;
            chk("wait_src_ready", src_ready, 1'b0);
            chk("wait_busy", busy, 1'b1);
            chk("wait_done", done, 1'b0);
        end
        @(negedge clk);
        core_done = 1'b1;
        #1;
        chk("done_pulse", done, 1'b1);
        @(negedge clk);
        core_done = 1'b0; src_valid = 1'b0; core_ready = 1'b0;
        #1;
        chk("done_clear", done, 1'b0);
        chk("post_busy", busy, 1'b0);
        chk("xfer_total", 64'(xfers), 64'(total));
        $display("op sel=%0d mode=%b msg_len=%0d transfers=%0d expected=%0d",
                 s, md, ml, xfers, total);
    endtask

    typedef struct {
        int         s;
        logic [1:0] md;
        int         ml;
        int         rdy;
        int         vld;
        int         inject;
        int         total;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{0, MODE_KEYGEN, 0,     100, 100, -1, 4};
        vecs[1] = '{0, MODE_SIGN,   264,   100, 100, -1, 321};
        vecs[2] = '{2, MODE_VERIFY, 0,     100, 100, -1, 899};
        vecs[3] = '{1, MODE_SIGN,   1000,  50,  70,  30, 516};
        vecs[4] = '{0, MODE_VERIFY, 26399, 60,  80,  5,  880};
        vecs[5] = '{2, MODE_KEYGEN, 77,    40,  50,  1,  4};
        vecs[6] = '{2, MODE_SIGN,   1,     70,  90,  -1, 609};
        vecs[7] = '{1, MODE_VERIFY, 64,    80,  60,  400, 657};

        rst = 1'b1; start = 1'b0; mode = 2'b00; msg_len = '0; sel = 2'd0;
        src_valid = 1'b0; src_data = '0; core_ready = 1'b0; core_done = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int s = 0; s < 3; s++) begin
            sel = 2'(s);
            #1;
            chk("reset_busy", busy, 1'b0);
            chk("reset_core_mode", core_mode, 2'b00);
            chk("reset_core_field", core_field, 4'd0);
        end
        sel = 2'd0;

        // Invalid mode: one-cycle err, no busy
        @(negedge clk);
        start = 1'b1; mode = MODE_INVALID;
        #1;
        chk("err_pulse", err, 1'b1);
        chk("err_busy", busy, 1'b0);
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("err_clear", err, 1'b0);
        chk("err_no_start", core_start, 1'b0);
        chk("err_busy_after", busy, 1'b0);

        // core_done while idle is ignored
        @(negedge clk);
        core_done = 1'b1;
        #1;
        chk("idle_core_done", done, 1'b0);
        @(negedge clk);
        core_done = 1'b0;

        for (int i = 0; i < 8; i++)
            run_op(vecs[i].s, vecs[i].md, vecs[i].ml, vecs[i].rdy, vecs[i].vld,
                   vecs[i].inject, -1, vecs[i].total);

        // Reset in the middle of a sign stream, then a clean keygen
        run_op(0, MODE_SIGN, 264, 100, 100, -1, 50, -1);
        run_op(0, MODE_KEYGEN, 0, 100, 100, -1, -1, 4);

        // Randomized operations checked against the reference model
        for (int i = 0; i < 5; i++) begin
            int         rs, rml;
            logic [1:0] rmd;
            rs  = $urandom_range(2);
            case ($urandom_range(2))
                0:       rmd = MODE_KEYGEN;
                1:       rmd = MODE_SIGN;
                default: rmd = MODE_VERIFY;
            endcase
            rml = ($urandom_range(3) == 0) ? 0 : $urandom_range(26399);
            run_op(rs, rmd, rml, $urandom_range(40, 100), $urandom_range(40, 100),
                   $urandom_range(0, 20), -1, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
